multicycle_control_unit: RTL and testbench

Multicycle MIPS control FSM that sequences each instruction over several clock cycles, sharing one ALU and one unified memory. It drives the multicycle datapath muxes and register/PC/IR write strobes. It is the sequential, parametrised successor of the single-cycle opcode decoder and adds a memory ready handshake with wait states. Optionally it adds an illegal-opcode trap. It sits between the instruction register (opcode source) and the multicycle datapath.

---
 rtl/multicycle_control_unit.sv | 152 +++++++++++++++
 tb/tb_multicycle_control_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM with memory ready handshake; outputs decoded from state.
// Optional illegal-opcode trap enabled by defining CTRL_TRAP_EN.
module multicycle_control_unit #(
  parameter int ALU_OP_W = 2
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic [5:0]          opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_source,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_2_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                instr_done,
  output logic                illegal_op,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEM_ADDR = 4'd3,
    S_MEM_RD = 4'd4, S_MEM_WB = 4'd5, S_MEM_WR = 4'd6, S_R_EXEC = 4'd7,
    S_R_WB = 4'd8, S_BEQ = 4'd9, S_JMP = 4'd10, S_ADDI_EX = 4'd11,
    S_ADDI_WB = 4'd12, S_TRAP = 4'd13
  } state_t;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = '0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_RT  = ALU_OP_W'(2);

  state_t     r_state;
  logic [5:0] r_opcode;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state  <= S_IDLE;
      r_opcode <= 6'h00;
    end else begin
      case (r_state)
        S_IDLE:     r_state <= S_FETCH;
        S_FETCH:    if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_opcode <= opcode;
          case (opcode)
            6'h23, 6'h2B: r_state <= S_MEM_ADDR;
            6'h00:        r_state <= S_R_EXEC;
            6'h04:        r_state <= S_BEQ;
            6'h02:        r_state <= S_JMP;
            6'h08:        r_state <= S_ADDI_EX;
`ifdef CTRL_TRAP_EN
            default:      r_state <= S_TRAP;
`else
            default:      r_state <= S_FETCH;
`endif
          endcase
        end
        // Load/store split uses the opcode captured in DECODE, not the live IR.
        S_MEM_ADDR: r_state <= (r_opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (mem_ready) r_state <= S_MEM_WB;
        S_MEM_WB:   r_state <= S_FETCH;
        S_MEM_WR:   if (mem_ready) r_state <= S_FETCH;
        S_R_EXEC:   r_state <= S_R_WB;
        S_R_WB:     r_state <= S_FETCH;
        S_BEQ:      r_state <= S_FETCH;
        S_JMP:      r_state <= S_FETCH;
        S_ADDI_EX:  r_state <= S_ADDI_WB;
        S_ADDI_WB:  r_state <= S_FETCH;
        S_TRAP:     r_state <= S_TRAP;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

`ifndef CTRL_TRAP_EN
  logic w_known;
  always_comb begin
    w_known = 1'b0;
    case (opcode)
      6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08: w_known = 1'b1;
      default:                                  w_known = 1'b0;
    endcase
  end
`endif

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_2_reg     = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = ALU_ADD;
    instr_done    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
`ifndef CTRL_TRAP_EN
        instr_done = ~w_known;
`endif
      end
      S_MEM_ADDR: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_MEM_RD:   begin mem_read = 1'b1; i_or_d = 1'b1; end
      S_MEM_WB:   begin reg_write = 1'b1; mem_2_reg = 1'b1; instr_done = 1'b1; end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_R_EXEC:   begin alu_src_a = 1'b1; alu_op = ALU_RT; end
      S_R_WB:     begin reg_write = 1'b1; reg_dst = 1'b1; instr_done = 1'b1; end
      S_BEQ: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_JMP:      begin pc_write = 1'b1; pc_source = 2'b10; instr_done = 1'b1; end
      S_ADDI_EX:  begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_ADDI_WB:  begin reg_write = 1'b1; instr_done = 1'b1; end
      default: ;
    endcase
  end

`ifdef CTRL_TRAP_EN
  assign illegal_op = (r_state == S_TRAP);
`else
  assign illegal_op = 1'b0;
`endif
  assign state = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized instruction streams with memory wait states, checked against a
// queue of expected (state, output) steps built from the instruction semantics.
module tb_multicycle_control_unit;
  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_2_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] state;

  multicycle_control_unit #(.ALU_OP_W(2)) dut (
    .clk(clk), .arst_n(arst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_2_reg(mem_2_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int         st;
    bit         mr;
    logic [5:0] op;
  } step_t;
  step_t q[$];

  logic [17:0] w_got;
  assign w_got = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                  ir_write, mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                  alu_op, instr_done, illegal_op};

  function automatic bit known(input logic [5:0] op);
    return op inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08};
  endfunction

  // Per-state output table: what the datapath must see in each phase.
  function automatic logic [17:0] exp_out(input int st, input bit mr, input logic [5:0] op);
    logic pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, done, ill;
    logic [1:0] ps, asb, aop;
    {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, done, ill} = '0;
    ps = 0; asb = 0; aop = 0;
    case (st)
      1:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      2: begin
        asb = 2'b11;
`ifndef CTRL_TRAP_EN
        if (!known(op)) done = 1;
`endif
      end
      3:  begin asa = 1; asb = 2'b10; end
      4:  begin mrd = 1; iod = 1; end
      5:  begin rw = 1; m2r = 1; done = 1; end
      6:  begin mwr = 1; iod = 1; done = mr; end
      7:  begin asa = 1; aop = 2; end
      8:  begin rw = 1; rd = 1; done = 1; end
      9:  begin asa = 1; aop = 1; pwc = 1; ps = 2'b01; done = 1; end
      10: begin pw = 1; ps = 2'b10; done = 1; end
      11: begin asa = 1; asb = 2'b10; end
      12: begin rw = 1; done = 1; end
      13: ill = 1;
      default: ;
    endcase
    return {pw, pwc, ps, iod, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, done, ill};
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom);
  endfunction

  task automatic push(input int st, input bit mr, input logic [5:0] op);
    step_t e;
    e.st = st; e.mr = mr; e.op = op;
    q.push_back(e);
  endtask

  // Expected step sequence for one instruction: FETCH waits, DECODE, then the op's phases.
  task automatic add_instr(input logic [5:0] op, input int wf, input int wm);
    for (int i = 0; i < wf; i++) push(1, 0, rnd_op());
    push(1, 1, rnd_op());
    push(2, 1'($urandom), op);
    case (op)
      6'h23: begin
        push(3, 1'($urandom), rnd_op());
        for (int i = 0; i < wm; i++) push(4, 0, rnd_op());
        push(4, 1, rnd_op());
        push(5, 1'($urandom), rnd_op());
      end
      6'h2B: begin
        push(3, 1'($urandom), rnd_op());
        for (int i = 0; i < wm; i++) push(6, 0, rnd_op());
        push(6, 1, rnd_op());
      end
      6'h00: begin push(7, 1'($urandom), rnd_op()); push(8, 1'($urandom), rnd_op()); end
      6'h04: push(9, 1'($urandom), rnd_op());
      6'h02: push(10, 1'($urandom), rnd_op());
      6'h08: begin push(11, 1'($urandom), rnd_op()); push(12, 1'($urandom), rnd_op()); end
      default: begin
`ifdef CTRL_TRAP_EN
        for (int i = 0; i < 10; i++) push(13, 1'($urandom), rnd_op());
`endif
      end
    endcase
  endtask

  // Entered just after a rising edge; each step checks on the falling edge.
  task automatic run_q();
    step_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      mem_ready = e.mr;
      opcode    = e.op;
      @(negedge clk);
      chk("state", state, e.st);
      chk("outs", w_got, exp_out(e.st, e.mr, e.op));
      chk("rw_excl", mem_read & mem_write, 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    mem_ready = 1'b1;
    #1 arst_n = 1'b0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_outs", w_got, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold", state, 0);
    chk("rst_hold_outs", w_got, 0);
    @(posedge clk);
    #1 arst_n = 1'b1;
    push(0, 1'($urandom), rnd_op());
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] ops [6];
    ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08};
    mem_ready = 1'b1;
    #12;
    chk("por_state", state, 0);
    chk("por_outs", w_got, 0);
    @(posedge clk);
    #1 arst_n = 1'b1;
    push(0, 1, 6'h00);

    // Directed: lw no wait, sw with 3 wait cycles, beq, j, unknown opcode.
    add_instr(6'h23, 0, 0); run_q();
    add_instr(6'h2B, 0, 3); run_q();
    add_instr(6'h04, 0, 0); run_q();
    add_instr(6'h02, 0, 0); run_q();
    add_instr(6'h3F, 1, 0); run_q();
`ifdef CTRL_TRAP_EN
    do_reset();
`endif

    // Reset while lw is stalled in MEM_RD.
    push(1, 1, 6'h00); push(2, 0, 6'h23); push(3, 0, 6'h2B);
    push(4, 0, 6'h2B); push(4, 0, 6'h00);
    run_q();
    do_reset();
    run_q();

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = rnd_op(); while (known(op));
      end else op = ops[$urandom_range(0, 5)];
      add_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
      run_q();
`ifdef CTRL_TRAP_EN
      if (!known(op)) begin do_reset(); run_q(); end
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
